// File: rtl/join_avalon_st_stream_pkg.sv
// Shared types and helpers for the Avalon-ST fragment joiner.
package join_avalon_st_stream_pkg;

  localparam int DATA_WIDTH_BYTES = 4;
  localparam int ACC_BYTES        = 8;

  typedef enum logic [1:0] {IDLE, MERGE, DROP, FLUSH} state_t;

  // Valid bytes carried by one sink beat; empty only means something on EOP.
  function automatic logic [2:0] bytes_of(input logic [1:0] empty, input logic eop);
    return eop ? (3'd4 - {1'b0, empty}) : 3'd4;
  endfunction

endpackage

// File: rtl/join_byte_accumulator.sv
// Big-endian byte buffer: pops from the head and appends behind the survivors in one cycle.
module join_byte_accumulator
  import join_avalon_st_stream_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic [2:0]  append_n,
  input  logic [31:0] append_data,
  input  logic [2:0]  pop_n,
  output logic [3:0]  acc_cnt,
  output logic [31:0] head
);

  logic [8*ACC_BYTES-1:0] bytes_q, bytes_d, shifted, inserted;
  logic [3:0]             cnt_q, cnt_d, base;
  logic [31:0]            keep_mask;

  // Bytes past cnt_q are always zero, so the head word needs no extra masking.
  always_comb begin
    base      = cnt_q - {1'b0, pop_n};
    keep_mask = ~(32'hFFFF_FFFF >> (8 * append_n));
    shifted   = bytes_q << (8 * pop_n);
    inserted  = {append_data & keep_mask, 32'h0} >> (8 * base);
    bytes_d   = shifted | inserted;
    cnt_d     = base + {1'b0, append_n};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bytes_q <= '0;
      cnt_q   <= '0;
    end else begin
      bytes_q <= bytes_d;
      cnt_q   <= cnt_d;
    end
  end

  assign acc_cnt = cnt_q;
  assign head    = bytes_q[8*ACC_BYTES-1 -: 32];

endmodule

// File: rtl/join_avalon_st_stream.sv
// Re-joins Avalon-ST fragments into one packet of packet_total_size_i bytes, packed densely.
// state | meaning
// IDLE  | waiting for the first fragment SOP
// MERGE | appending fragment bytes until the packet byte count is reached
// DROP  | packet full before a fragment EOP; discarding until that EOP
// FLUSH | input closed; draining the accumulator and output register
module join_avalon_st_stream
  import join_avalon_st_stream_pkg::*;
#(
  parameter int DATA_WIDTH    = 32,
  parameter int EMPTY_WIDTH   = 2,
  parameter int PAC_MAX_WIDTH = 16
) (
  input  logic                     clk_i,
  input  logic                     reset_n_i,
  input  logic [PAC_MAX_WIDTH-1:0] packet_total_size_i,
  input  logic                     asi_snk_valid_i,
  output logic                     asi_snk_ready_o,
  input  logic [DATA_WIDTH-1:0]    asi_snk_data_i,
  input  logic [EMPTY_WIDTH-1:0]   asi_snk_empty_i,
  input  logic                     asi_snk_startofpacket_i,
  input  logic                     asi_snk_endofpacket_i,
  output logic                     aso_src_valid_o,
  input  logic                     aso_src_ready_i,
  output logic [DATA_WIDTH-1:0]    aso_src_data_o,
  output logic [EMPTY_WIDTH-1:0]   aso_src_empty_o,
  output logic                     aso_src_startofpacket_o,
  output logic                     aso_src_endofpacket_o,
  output logic                     err_overrun_o,
  output logic                     err_nosop_o
);

  state_t                   state_q, state_d;
  logic [PAC_MAX_WIDTH-1:0] rem_in_q, rem_in_d, rem_out_q, need, rem_after, word_len;
  logic                     run_q, sop_pend_q;
  logic [3:0]               acc_cnt;
  logic [31:0]              acc_head;
  logic                     accept, append_en, load, load_ok, snk_ready;
  logic                     overrun, nosop;
  logic [2:0]               beat_bytes, app_n, pop_n, word_bytes;

  join_byte_accumulator u_acc (
    .clk         (clk_i),
    .rst_n       (reset_n_i),
    .append_n    (app_n),
    .append_data (asi_snk_data_i),
    .pop_n       (pop_n),
    .acc_cnt     (acc_cnt),
    .head        (acc_head)
  );

  always_comb begin
    need       = (state_q == IDLE) ? packet_total_size_i : rem_in_q;
    beat_bytes = bytes_of(asi_snk_empty_i, asi_snk_endofpacket_i);
    load_ok    = !aso_src_valid_o || aso_src_ready_i;
    load       = load_ok && ((acc_cnt >= 4'(DATA_WIDTH_BYTES)) ||
                             (acc_cnt != 4'd0 && rem_in_q == '0));
    word_bytes = (acc_cnt >= 4'(DATA_WIDTH_BYTES)) ? 3'(DATA_WIDTH_BYTES) : acc_cnt[2:0];
    word_len   = PAC_MAX_WIDTH'(word_bytes);
    pop_n      = load ? word_bytes : 3'd0;

    case (state_q)
      IDLE:    snk_ready = run_q && (packet_total_size_i != '0);
      MERGE:   snk_ready = (acc_cnt <= 4'd4) || load;
      DROP:    snk_ready = 1'b1;
      default: snk_ready = 1'b0;
    endcase
    accept    = asi_snk_valid_i && snk_ready;
    append_en = accept && ((state_q == MERGE) ||
                           (state_q == IDLE && asi_snk_startofpacket_i));

    // Never take more than the packet still needs; excess bytes are an overrun.
    if (!append_en)
      app_n = 3'd0;
    else if (need < PAC_MAX_WIDTH'(beat_bytes))
      app_n = need[2:0];
    else
      app_n = beat_bytes;
    rem_after = need - PAC_MAX_WIDTH'(app_n);

    state_d  = state_q;
    rem_in_d = rem_in_q;
    overrun  = 1'b0;
    nosop    = 1'b0;
    case (state_q)
      IDLE, MERGE: begin
        if (append_en) begin
          rem_in_d = rem_after;
          if (rem_after != '0) begin
            state_d = MERGE;
          end else if (asi_snk_endofpacket_i) begin
            state_d = FLUSH;
          end else begin
            overrun = 1'b1;
            state_d = DROP;
          end
        end else if (accept && state_q == IDLE) begin
          nosop = 1'b1;
        end
      end
      DROP: begin
        if (accept && asi_snk_endofpacket_i)
          state_d = (acc_cnt == 4'd0) ? IDLE : FLUSH;
      end
      FLUSH: begin
        if (acc_cnt == 4'd0 && load_ok)
          state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign asi_snk_ready_o = snk_ready;

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q                 <= IDLE;
      run_q                   <= 1'b0;
      rem_in_q                <= '0;
      rem_out_q               <= '0;
      sop_pend_q              <= 1'b0;
      err_overrun_o           <= 1'b0;
      err_nosop_o             <= 1'b0;
      aso_src_valid_o         <= 1'b0;
      aso_src_data_o          <= '0;
      aso_src_empty_o         <= '0;
      aso_src_startofpacket_o <= 1'b0;
      aso_src_endofpacket_o   <= 1'b0;
    end else begin
      run_q         <= 1'b1;
      state_q       <= state_d;
      rem_in_q      <= rem_in_d;
      err_overrun_o <= overrun;
      err_nosop_o   <= nosop;

      // The accumulator is empty in IDLE, so a packet start never coincides with a load.
      if (state_q == IDLE && append_en) begin
        rem_out_q  <= packet_total_size_i;
        sop_pend_q <= 1'b1;
      end else if (load) begin
        rem_out_q  <= (rem_out_q > word_len) ? rem_out_q - word_len : '0;
        sop_pend_q <= 1'b0;
      end

      if (load) begin
        aso_src_valid_o         <= 1'b1;
        aso_src_data_o          <= acc_head;
        aso_src_empty_o         <= EMPTY_WIDTH'(3'd4 - word_bytes);
        aso_src_startofpacket_o <= sop_pend_q;
        aso_src_endofpacket_o   <= (rem_out_q <= word_len);
      end else if (aso_src_ready_i) begin
        aso_src_valid_o <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_join_avalon_st_stream.sv
// Scoreboard bench: expected words come from a byte-list model of each packet.
module tb_join_avalon_st_stream;

  logic        clk_i = 1'b0;
  logic        reset_n_i = 1'b0;
  logic [15:0] packet_total_size_i = 16'd7;
  logic        asi_snk_valid_i = 1'b0;
  logic        asi_snk_ready_o;
  logic [31:0] asi_snk_data_i = '0;
  logic [1:0]  asi_snk_empty_i = '0;
  logic        asi_snk_startofpacket_i = 1'b0;
  logic        asi_snk_endofpacket_i = 1'b0;
  logic        aso_src_valid_o;
  logic        aso_src_ready_i = 1'b1;
  logic [31:0] aso_src_data_o;
  logic [1:0]  aso_src_empty_o;
  logic        aso_src_startofpacket_o;
  logic        aso_src_endofpacket_o;
  logic        err_overrun_o;
  logic        err_nosop_o;

  join_avalon_st_stream dut (
    .clk_i                   (clk_i),
    .reset_n_i               (reset_n_i),
    .packet_total_size_i     (packet_total_size_i),
    .asi_snk_valid_i         (asi_snk_valid_i),
    .asi_snk_ready_o         (asi_snk_ready_o),
    .asi_snk_data_i          (asi_snk_data_i),
    .asi_snk_empty_i         (asi_snk_empty_i),
    .asi_snk_startofpacket_i (asi_snk_startofpacket_i),
    .asi_snk_endofpacket_i   (asi_snk_endofpacket_i),
    .aso_src_valid_o         (aso_src_valid_o),
    .aso_src_ready_i         (aso_src_ready_i),
    .aso_src_data_o          (aso_src_data_o),
    .aso_src_empty_o         (aso_src_empty_o),
    .aso_src_startofpacket_o (aso_src_startofpacket_o),
    .aso_src_endofpacket_o   (aso_src_endofpacket_o),
    .err_overrun_o           (err_overrun_o),
    .err_nosop_o             (err_nosop_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct packed {
    logic [31:0] data;
    logic [1:0]  empty;
    logic        sop;
    logic        eop;
  } word_t;

  word_t      exp_q[$];
  logic [7:0] pkt_bytes[$];
  int         errors = 0;
  int         checks = 0;
  int         n_ovr = 0;
  int         n_nosop = 0;
  int         ready_mode = 0;  // 0: ready high, 1: ready low, 2: random
  bit         gaps = 0;
  bit         scramble = 0;
  bit         bp_phase = 0;
  bit         saw_stall = 0;
  bit         held = 0;
  word_t      held_w, mon_act, mon_exp;

  initial forever begin
    @(posedge clk_i);
    #1;
    case (ready_mode)
      0:       aso_src_ready_i = 1'b1;
      1:       aso_src_ready_i = 1'b0;
      default: aso_src_ready_i = ($urandom_range(0, 3) != 0);
    endcase
  end

  // Monitor: samples on the falling edge, between input updates and the accepting edge.
  always @(negedge clk_i) begin
    if (!reset_n_i) begin
      held = 0;
    end else begin
      mon_act = {aso_src_data_o, aso_src_empty_o, aso_src_startofpacket_o, aso_src_endofpacket_o};
      if (held) begin
        checks++;
        if (!aso_src_valid_o || mon_act !== held_w) begin
          errors++;
          $display("FAIL hold_stable: got v=%0b %h/%0d/%0b/%0b, required v=1 %h/%0d/%0b/%0b",
                   aso_src_valid_o, mon_act.data, mon_act.empty, mon_act.sop, mon_act.eop,
                   held_w.data, held_w.empty, held_w.sop, held_w.eop);
        end
      end
      if (aso_src_valid_o && aso_src_ready_i) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL out_word: got %h/%0d/%0b/%0b, required no output",
                   mon_act.data, mon_act.empty, mon_act.sop, mon_act.eop);
        end else begin
          mon_exp = exp_q.pop_front();
          if (mon_act !== mon_exp) begin
            errors++;
            $display("FAIL out_word: got d=%h e=%0d sop=%0b eop=%0b, required d=%h e=%0d sop=%0b eop=%0b",
                     mon_act.data, mon_act.empty, mon_act.sop, mon_act.eop,
                     mon_exp.data, mon_exp.empty, mon_exp.sop, mon_exp.eop);
          end
        end
      end
      held   = aso_src_valid_o && !aso_src_ready_i;
      held_w = mon_act;
      if (err_overrun_o) n_ovr++;
      if (err_nosop_o) n_nosop++;
      if (bp_phase && asi_snk_valid_i && !asi_snk_ready_o) saw_stall = 1;
    end
  end

  // Reference: the packet is just its byte list, cut into 4-byte words.
  task automatic model_packet();
    int n = pkt_bytes.size();
    for (int i = 0; i < n; i += 4) begin
      word_t w;
      int k;
      k = (n - i >= 4) ? 4 : n - i;
      w.data = '0;
      for (int j = 0; j < k; j++) w.data[31-8*j -: 8] = pkt_bytes[i+j];
      w.empty = 2'(4 - k);
      w.sop   = (i == 0);
      w.eop   = (i + 4 >= n);
      exp_q.push_back(w);
    end
  endtask

  task automatic fill_seq(input int n, input logic [7:0] first);
    pkt_bytes.delete();
    for (int i = 0; i < n; i++) pkt_bytes.push_back(first + 8'(i));
  endtask

  task automatic fill_random(input int n);
    pkt_bytes.delete();
    for (int i = 0; i < n; i++) pkt_bytes.push_back(8'($urandom));
  endtask

  task automatic send_beat(input logic [31:0] d, input logic [1:0] e, input logic s, input logic eo);
    int t = 0;
    asi_snk_data_i          = d;
    asi_snk_empty_i         = e;
    asi_snk_startofpacket_i = s;
    asi_snk_endofpacket_i   = eo;
    asi_snk_valid_i         = 1'b1;
    @(negedge clk_i);
    while (!asi_snk_ready_o && t < 1000) begin
      @(negedge clk_i);
      t++;
    end
    if (!asi_snk_ready_o) begin
      checks++;
      errors++;
      $display("FAIL snk_timeout: ready=%0b after %0d cycles, required 1", asi_snk_ready_o, t);
    end else begin
      @(posedge clk_i);
    end
    #1;
    asi_snk_valid_i = 1'b0;
  endtask

  // One fragment of len bytes from pkt_bytes[start]; filler bytes and non-EOP empties are junk.
  task automatic send_frag(input int start, input int len);
    int nb = (len + 3) / 4;
    for (int b = 0; b < nb; b++) begin
      logic [31:0] d;
      logic [1:0]  e;
      int          k;
      d = $urandom;
      k = (b == nb - 1) ? len - 4 * b : 4;
      for (int j = 0; j < k; j++) d[31-8*j -: 8] = pkt_bytes[start + 4*b + j];
      e = (b == nb - 1) ? 2'(4 - k) : 2'($urandom);
      send_beat(d, e, b == 0, b == nb - 1);
      if (gaps && $urandom_range(0, 3) == 0) begin
        repeat ($urandom_range(1, 3)) @(posedge clk_i);
        #1;
      end
    end
  endtask

  task automatic send_packet(input int total);
    int pos = 0;
    int len;
    model_packet();
    packet_total_size_i = 16'(total);
    while (pos < total) begin
      len = $urandom_range(1, (total - pos) < 8 ? total - pos : 8);
      send_frag(pos, len);
      pos += len;
      if (scramble) packet_total_size_i = 16'($urandom);
    end
  endtask

  task automatic wait_drain(input string name);
    int t = 0;
    while (exp_q.size() != 0 && t < 2000) begin
      @(posedge clk_i);
      t++;
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL %s: %0d words still pending, required 0", name, exp_q.size());
      exp_q.delete();
    end
    repeat (4) @(posedge clk_i);
    #1;
  endtask

  task automatic check_zero_outputs(input string name);
    logic [39:0] v;
    v = {asi_snk_ready_o, aso_src_valid_o, aso_src_data_o, aso_src_empty_o,
         aso_src_startofpacket_o, aso_src_endofpacket_o, err_overrun_o, err_nosop_o};
    checks++;
    if (v !== '0) begin
      errors++;
      $display("FAIL %s: outputs=%h, required all zero", name, v);
    end
  endtask

  task automatic check_count(input string name, input int got, input int want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s: got %0d, required %0d", name, got, want);
    end
  endtask

  initial begin
    int ovr0, nos0;
    repeat (3) @(posedge clk_i);
    #1;
    check_zero_outputs("reset_outputs");
    reset_n_i = 1'b1;
    @(posedge clk_i);
    #1;

    // 4-byte then 3-byte fragment -> 00010203, 04050600
    fill_seq(7, 8'h00);
    model_packet();
    packet_total_size_i = 16'd7;
    send_frag(0, 4);
    send_frag(4, 3);
    wait_drain("drain_tp1");

    // 2-byte then 4-byte fragment -> AABB0001, 02030000
    pkt_bytes = '{8'hAA, 8'hBB, 8'h00, 8'h01, 8'h02, 8'h03};
    model_packet();
    packet_total_size_i = 16'd6;
    send_frag(0, 2);
    send_frag(2, 4);
    wait_drain("drain_tp2");

    // Overrun: total 5, second fragment lacks EOP where the packet fills
    ovr0 = n_ovr;
    fill_seq(5, 8'h00);
    model_packet();
    packet_total_size_i = 16'd5;
    send_beat(32'h00010203, 2'd0, 1'b1, 1'b1);
    send_beat(32'h04050607, 2'd0, 1'b1, 1'b0);
    send_beat(32'h08090A0B, 2'd0, 1'b0, 1'b0);
    send_beat(32'h0C0D0E0F, 2'd0, 1'b0, 1'b1);
    wait_drain("drain_overrun");
    check_count("overrun_pulses", n_ovr - ovr0, 1);

    // Beat without SOP in IDLE is dropped with a pulse
    nos0 = n_nosop;
    packet_total_size_i = 16'd9;
    send_beat($urandom, 2'd0, 1'b0, 1'b1);
    repeat (3) @(posedge clk_i);
    #1;
    check_count("nosop_pulses", n_nosop - nos0, 1);
    check_count("nosop_no_overrun", n_ovr - ovr0, 1);

    // Zero total size keeps the sink closed
    packet_total_size_i = 16'd0;
    asi_snk_data_i = $urandom;
    asi_snk_startofpacket_i = 1'b1;
    asi_snk_endofpacket_i = 1'b1;
    asi_snk_empty_i = 2'd0;
    asi_snk_valid_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk_i);
      check_count("ready_total_zero", int'(asi_snk_ready_o), 0);
    end
    @(posedge clk_i);
    #1;
    asi_snk_valid_i = 1'b0;
    wait_drain("drain_total_zero");

    // Output stalled mid-packet: sink must close once the accumulator fills
    ready_mode = 1;
    @(posedge clk_i);
    #2;
    bp_phase = 1;
    saw_stall = 0;
    fill_random(16);
    model_packet();
    packet_total_size_i = 16'd16;
    fork
      begin
        send_frag(0, 4);
        send_frag(4, 4);
        send_frag(8, 4);
        send_frag(12, 4);
      end
      begin
        repeat (10) @(posedge clk_i);
        ready_mode = 0;
      end
    join
    wait_drain("drain_backpressure");
    bp_phase = 0;
    check_count("snk_stall_seen", int'(saw_stall), 1);

    // Reset with 3 bytes held: nothing may come out afterwards
    packet_total_size_i = 16'd12;
    send_beat($urandom, 2'd1, 1'b1, 1'b1);
    repeat (2) @(posedge clk_i);
    @(negedge clk_i);
    #2;
    reset_n_i = 1'b0;
    #1;
    check_zero_outputs("midreset_outputs");
    repeat (2) @(posedge clk_i);
    #1;
    reset_n_i = 1'b1;
    @(posedge clk_i);
    #1;

    // Randomized packets with random fragmenting, gaps and output stalls
    ovr0 = n_ovr;
    nos0 = n_nosop;
    ready_mode = 2;
    gaps = 1;
    scramble = 1;
    for (int p = 0; p < 40; p++) begin
      int total = $urandom_range(1, 24);
      fill_random(total);
      send_packet(total);
    end
    wait_drain("drain_random");
    ready_mode = 0;
    @(posedge clk_i);
    #2;
    check_count("random_overrun_pulses", n_ovr - ovr0, 0);
    check_count("random_nosop_pulses", n_nosop - nos0, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2_000_000;
    errors++;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1, "watchdog");
  end

endmodule
